io_pad_ctrl: RTL and testbench

- Wishbone-configurable pad controller for the user project IO ring; the parametrised successor to hard-wired per-pin oeb/out assignment and the fixed 2FF input synchronizer.
- Per pad: output enable, output source (GPIO register or one of NCH peripheral channels), synchronizer, debouncer and sticky rising-edge capture with interrupt.
- Sits between the user-project top-level pads and the peripheral cores (dinogame instances, crypto accelerator); shares the Wishbone slave port through an address decoder.

---
 rtl/io_pad_ctrl_if.sv | 21 ++
 rtl/io_pad_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_io_pad_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/io_pad_ctrl_if.sv
// rtl/io_pad_ctrl_if.sv - Wishbone-style register bus bundle for the pad controller
interface io_pad_ctrl_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [7:0]  addr;
  logic [31:0] data_wr;
  logic        ack;
  logic [31:0] data_rd;

  modport master (
    output cyc, stb, we, sel, addr, data_wr,
    input  ack, data_rd
  );

  modport slave (
    input  cyc, stb, we, sel, addr, data_wr,
    output ack, data_rd
  );
endinterface

// File: rtl/io_pad_ctrl.sv
// rtl/io_pad_ctrl.sv - per-pad output muxing, input sync/debounce and edge interrupt
module io_pad_ctrl #(
  parameter int NPADS       = 32,
  parameter int NCH         = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_W       = 16,
  parameter int DEB_RESET   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  io_pad_ctrl_if.slave           bus,
  input  logic [NPADS-1:0]       pad_in,
  output logic [NPADS-1:0]       pad_out,
  output logic [NPADS-1:0]       pad_oeb,
  input  logic [NCH*NPADS-1:0]   periph_out,
  input  logic [NCH*NPADS-1:0]   periph_oeb,
  output logic [NPADS-1:0]       in_sync,
  output logic                   irq
);

  localparam logic [DEB_W-1:0] DEB_INIT = DEB_W'(DEB_RESET);

  localparam logic [2:0] R_OEB    = 3'd0;
  localparam logic [2:0] R_GPIO   = 3'd1;
  localparam logic [2:0] R_SRC_LO = 3'd2;
  localparam logic [2:0] R_SRC_HI = 3'd3;
  localparam logic [2:0] R_IN     = 3'd4;
  localparam logic [2:0] R_EDGE   = 3'd5;
  localparam logic [2:0] R_IRQ_EN = 3'd6;
  localparam logic [2:0] R_DEB    = 3'd7;

  // Configuration registers
  logic [NPADS-1:0] oeb_q, oeb_d;
  logic [NPADS-1:0] gpio_q, gpio_d;
  logic [NPADS-1:0] irq_en_q, irq_en_d;
  logic [NPADS-1:0] edge_q, edge_d;
  logic [63:0]      src_q, src_d;      // 2 bits per pad; bits beyond 2*NPADS stay 0
  logic [DEB_W-1:0] deb_cfg_q, deb_cfg_d;

  // Input path state
  logic [NPADS-1:0] sync_q [SYNC_STAGES];
  logic [NPADS-1:0] sync_d [SYNC_STAGES];
  logic [NPADS-1:0] deb_q, deb_d;
  logic [DEB_W-1:0] cnt_q [NPADS];
  logic [DEB_W-1:0] cnt_d [NPADS];

  // Bus and interrupt state
  logic        ack_q, ack_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;

  logic             req;
  logic             wr_en;
  logic             deb_cfg_wr;
  logic [2:0]       reg_idx;
  logic [NPADS-1:0] edge_clr;
  logic [NPADS-1:0] sync_s;
  logic [NPADS-1:0] rise;
  logic [DEB_W-1:0] n_m1;
  logic [31:0]      rd_word;
  logic             unused_addr;

  // A request is serviced only when no ack is outstanding, so back-to-back
  // strobes are acked every other cycle.
  assign req         = bus.cyc & bus.stb & ~ack_q;
  assign wr_en       = req & bus.we;
  assign reg_idx     = bus.addr[4:2];
  assign deb_cfg_wr  = wr_en && (reg_idx == R_DEB);
  assign unused_addr = ^{bus.addr[7:5], bus.addr[1:0]};

  assign bus.ack     = ack_q;
  assign bus.data_rd = rdata_q;
  assign in_sync     = deb_q;
  assign irq         = irq_q;
  assign sync_s      = sync_q[SYNC_STAGES-1];

  // Register writes with per-byte lane enables; EDGE writes produce a clear mask
  always_comb begin
    oeb_d     = oeb_q;
    gpio_d    = gpio_q;
    irq_en_d  = irq_en_q;
    src_d     = src_q;
    deb_cfg_d = deb_cfg_q;
    edge_clr  = '0;
    for (int i = 0; i < NPADS; i++) begin
      if (wr_en && bus.sel[i/8]) begin
        case (reg_idx)
          R_OEB:    oeb_d[i]    = bus.data_wr[i];
          R_GPIO:   gpio_d[i]   = bus.data_wr[i];
          R_EDGE:   edge_clr[i] = bus.data_wr[i];
          R_IRQ_EN: irq_en_d[i] = bus.data_wr[i];
          default:  ;
        endcase
      end
    end
    for (int j = 0; j < 2*NPADS; j++) begin
      if (wr_en && bus.sel[(j%32)/8] && (reg_idx == 3'(2 + j/32)))
        src_d[j] = bus.data_wr[j%32];
    end
    for (int k = 0; k < DEB_W; k++) begin
      if (deb_cfg_wr && bus.sel[k/8])
        deb_cfg_d[k] = bus.data_wr[k];
    end
  end

  // Read mux; data is presented only alongside the ack pulse
  always_comb begin
    rd_word = '0;
    case (reg_idx)
      R_OEB:    rd_word[NPADS-1:0] = oeb_q;
      R_GPIO:   rd_word[NPADS-1:0] = gpio_q;
      R_SRC_LO: rd_word            = src_q[31:0];
      R_SRC_HI: rd_word            = src_q[63:32];
      R_IN:     rd_word[NPADS-1:0] = deb_q;
      R_EDGE:   rd_word[NPADS-1:0] = edge_q;
      R_IRQ_EN: rd_word[NPADS-1:0] = irq_en_q;
      R_DEB:    rd_word[DEB_W-1:0] = deb_cfg_q;
      default:  rd_word            = '0;
    endcase
    ack_d   = req;
    rdata_d = req ? rd_word : '0;
  end

  // Synchronizer chain, debounce counters, sticky edge capture and irq
  always_comb begin
    sync_d[0] = pad_in;
    for (int s = 1; s < SYNC_STAGES; s++)
      sync_d[s] = sync_q[s-1];

    // A zero threshold behaves as one: the stage then just follows s.
    n_m1 = (deb_cfg_q == '0) ? '0 : deb_cfg_q - 1'b1;

    deb_d = deb_q;
    for (int p = 0; p < NPADS; p++) begin
      cnt_d[p] = cnt_q[p];
      if (sync_s[p] == deb_q[p]) begin
        cnt_d[p] = '0;
      end else if (cnt_q[p] == n_m1) begin
        deb_d[p] = sync_s[p];
        cnt_d[p] = '0;
      end else begin
        cnt_d[p] = cnt_q[p] + 1'b1;
      end
      // Retuning the threshold restarts every count and freezes d for this edge.
      if (deb_cfg_wr) begin
        cnt_d[p] = '0;
        deb_d[p] = deb_q[p];
      end
    end

    // A new rising edge wins over a simultaneous W1C clear.
    rise   = deb_d & ~deb_q;
    edge_d = (edge_q & ~edge_clr) | rise;
    irq_d  = |(edge_q & irq_en_q);
  end

  // Output source select: 0 or out-of-range picks the GPIO registers
  always_comb begin
    logic [1:0] k;
    k       = '0;
    pad_out = '0;
    pad_oeb = '1;
    for (int p = 0; p < NPADS; p++) begin
      k          = src_q[2*p +: 2];
      pad_out[p] = gpio_q[p];
      pad_oeb[p] = oeb_q[p];
      if ((k != 2'd0) && (int'(k) <= NCH)) begin
        pad_out[p] = periph_out[(int'(k) - 1) * NPADS + p];
        pad_oeb[p] = periph_oeb[(int'(k) - 1) * NPADS + p];
      end
    end
  end

  // State update with asynchronous reset of every flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oeb_q     <= '1;
      gpio_q    <= '0;
      irq_en_q  <= '0;
      edge_q    <= '0;
      src_q     <= '0;
      deb_cfg_q <= DEB_INIT;
      deb_q     <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= '0;
      for (int p = 0; p < NPADS; p++)
        cnt_q[p] <= '0;
    end else begin
      oeb_q     <= oeb_d;
      gpio_q    <= gpio_d;
      irq_en_q  <= irq_en_d;
      edge_q    <= edge_d;
      src_q     <= src_d;
      deb_cfg_q <= deb_cfg_d;
      deb_q     <= deb_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
      for (int s = 0; s < SYNC_STAGES; s++)
        sync_q[s] <= sync_d[s];
      for (int p = 0; p < NPADS; p++)
        cnt_q[p] <= cnt_d[p];
    end
  end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// tb/tb_io_pad_ctrl.sv - directed self-checking bench for io_pad_ctrl
module tb_io_pad_ctrl;
  localparam int NPADS = 32;
  localparam int NCH   = 2;

  logic                 clk;
  logic                 rst;
  logic [NPADS-1:0]     pad_in;
  logic [NPADS-1:0]     pad_out;
  logic [NPADS-1:0]     pad_oeb;
  logic [NCH*NPADS-1:0] periph_out;
  logic [NCH*NPADS-1:0] periph_oeb;
  logic [NPADS-1:0]     in_sync;
  logic                 irq;
  logic [31:0]          rd;

  int checks = 0;
  int errors = 0;

  io_pad_ctrl_if bus_if ();

  io_pad_ctrl #(
    .NPADS(NPADS), .NCH(NCH), .SYNC_STAGES(2), .DEB_W(16), .DEB_RESET(0)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .pad_in(pad_in), .pad_out(pad_out), .pad_oeb(pad_oeb),
    .periph_out(periph_out), .periph_oeb(periph_oeb),
    .in_sync(in_sync), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    if (bus_if.ack) tick(1);
    bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b1;
    bus_if.addr = a; bus_if.data_wr = d; bus_if.sel = s;
    tick(1);
    check("wr_ack", {31'd0, bus_if.ack}, 32'd1);
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    if (bus_if.ack) tick(1);
    bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b0;
    bus_if.addr = a; bus_if.sel = 4'hF;
    tick(1);
    check("rd_ack", {31'd0, bus_if.ack}, 32'd1);
    d = bus_if.data_rd;
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    pad_in = '0; periph_out = '0; periph_oeb = '0;
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
    bus_if.sel = 4'h0; bus_if.addr = 8'h00; bus_if.data_wr = '0;
    tick(2);
    check("rst_oeb", pad_oeb, 32'hFFFF_FFFF);
    check("rst_out", pad_out, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, bus_if.ack}, 32'd0);
    rst = 1'b0;
    tick(1);

    bus_read(8'h00, rd); check("rd_oeb", rd, 32'hFFFF_FFFF);
    check("rd_idle_zero", bus_if.data_rd, 32'h0);
    bus_read(8'h08, rd); check("rd_src_lo", rd, 32'h0);
    bus_read(8'h1C, rd); check("rd_deb_cfg", rd, 32'h0);

    bus_write(8'h04, 32'h0000_00A5, 4'hF);
    bus_write(8'h00, 32'hFFFF_FF00, 4'hF);
    check("gpio_out", pad_out, 32'h0000_00A5);
    check("gpio_oeb", pad_oeb, 32'hFFFF_FF00);
    bus_write(8'h04, 32'hFFFF_FFFF, 4'b0001);
    bus_write(8'h04, 32'hC3AA_BBCC, 4'b1000);
    check("sel_bytes", pad_out, 32'hC300_00FF);
    bus_read(8'h04, rd); check("rd_gpio", rd, 32'hC300_00FF);

    periph_out[NPADS+3] = 1'b0;
    periph_oeb[NPADS+3] = 1'b1;
    periph_out[3] = 1'b1;
    bus_write(8'h08, 32'h0000_0080, 4'hF);
    check("ch1_out0", pad_out, 32'hC300_00F7);
    check("ch1_oeb1", pad_oeb, 32'hFFFF_FF08);
    periph_out[NPADS+3] = 1'b1; #1;
    check("ch1_out1", pad_out, 32'hC300_00FF);
    periph_oeb[NPADS+3] = 1'b0; #1;
    check("ch1_oeb0", pad_oeb, 32'hFFFF_FF00);
    periph_out[NPADS+3] = 1'b0;
    periph_oeb[NPADS+3] = 1'b1;
    bus_write(8'h08, 32'h0000_00C0, 4'hF);
    check("src3_out", pad_out, 32'hC300_00FF);
    check("src3_oeb", pad_oeb, 32'hFFFF_FF00);

    bus_write(8'h1C, 32'h0000_0004, 4'hF);
    tick(1);
    pad_in[5] = 1'b1;
    tick(3);
    pad_in[5] = 1'b0;
    tick(8);
    check("glitch_in", in_sync, 32'h0);
    bus_read(8'h14, rd); check("glitch_edge", rd, 32'h0);

    pad_in[5] = 1'b1;
    tick(5);
    check("deb_lat5", in_sync, 32'h0);
    tick(1);
    check("deb_lat6", in_sync, 32'h0000_0020);
    bus_read(8'h10, rd); check("rd_in", rd, 32'h0000_0020);
    bus_read(8'h14, rd); check("edge_set", rd, 32'h0000_0020);
    check("irq_masked", {31'd0, irq}, 32'd0);

    bus_write(8'h18, 32'h0000_0020, 4'hF);
    check("irq_before", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_on", {31'd0, irq}, 32'd1);
    bus_write(8'h14, 32'h0000_0020, 4'hF);
    check("irq_hold", {31'd0, irq}, 32'd1);
    tick(1);
    check("irq_off", {31'd0, irq}, 32'd0);
    bus_read(8'h14, rd); check("edge_w1c", rd, 32'h0);

    pad_in[5] = 1'b0;
    tick(10);
    check("fall_in", in_sync, 32'h0);
    bus_read(8'h14, rd); check("fall_no_edge", rd, 32'h0);
    pad_in[5] = 1'b1;
    tick(5);
    bus_write(8'h14, 32'h0000_0020, 4'hF);
    check("coinc_in", in_sync, 32'h0000_0020);
    bus_read(8'h14, rd); check("set_wins", rd, 32'h0000_0020);
    check("coinc_irq", {31'd0, irq}, 32'd1);

    pad_in[6] = 1'b1;
    tick(3);
    bus_if.cyc = 1'b1; bus_if.stb = 1'b1; bus_if.we = 1'b1;
    bus_if.addr = 8'h04; bus_if.data_wr = 32'h0; bus_if.sel = 4'hF;
    tick(1);
    check("mid_ack", {31'd0, bus_if.ack}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_ack", {31'd0, bus_if.ack}, 32'd0);
    check("arst_out", pad_out, 32'h0);
    check("arst_oeb", pad_oeb, 32'hFFFF_FFFF);
    check("arst_in", in_sync, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    bus_if.cyc = 1'b0; bus_if.stb = 1'b0; bus_if.we = 1'b0;
    tick(1);
    rst = 1'b0;
    tick(1);
    check("post_ack", {31'd0, bus_if.ack}, 32'd0);
    bus_read(8'h00, rd); check("post_oeb", rd, 32'hFFFF_FFFF);
    bus_read(8'h1C, rd); check("post_deb", rd, 32'h0);
    bus_read(8'h08, rd); check("post_src", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
